// File: rtl/controlador_matriz.sv
// rtl/controlador_matriz.sv - handshaked row sequencer for the 5x5 int8 matrix-multiply datapath
module controlador_matriz #(
    parameter int DP_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [199:0] matriz_a,
    input  logic [199:0] matriz_b,
    output logic         busy,
    output logic         done,
    output logic [199:0] resultado,
    output logic [199:0] dp_matriz_a,
    output logic [199:0] dp_matriz_b,
    output logic [2:0]   dp_linha,
    output logic         dp_valid,
    input  logic [39:0]  dp_linha_resultado
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [199:0] a_q, a_d;
    logic [199:0] b_q, b_d;
    logic [199:0] res_q, res_d;
    // Each stage holds {valid, row tag}; stage 0 doubles as the issue register.
    logic [3:0]   pipe_q [DP_LATENCY];
    logic [3:0]   pipe_d [DP_LATENCY];
    logic         tap_valid;
    logic [2:0]   tap_tag;
    logic         last_capture;

    always_comb begin
        tap_valid    = pipe_q[DP_LATENCY-1][3];
        tap_tag      = pipe_q[DP_LATENCY-1][2:0];
        last_capture = tap_valid && (tap_tag == 3'd4);
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        pipe_d[0]    = 4'b0000;
        for (int i = 1; i < DP_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        for (int r = 0; r < 5; r++) begin
            if (tap_valid && (tap_tag == 3'(r))) begin
                res_d[40*r +: 40] = dp_linha_resultado;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                    a_d       = matriz_a;
                    b_d       = matriz_b;
                    pipe_d[0] = 4'b1000;
                end
            end
            ISSUE: begin
                if (cnt_q == 3'd4) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d     = cnt_q + 3'd1;
                    pipe_d[0] = {1'b1, cnt_q + 3'd1};
                end
            end
            DRAIN:   state_d = DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With a short latency the last row can land while still in ISSUE.
        if (last_capture) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                pipe_q[i] <= 4'b0000;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            for (int i = 0; i < DP_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign resultado   = res_q;
    assign dp_matriz_a = a_q;
    assign dp_matriz_b = b_q;
    assign dp_valid    = pipe_q[0][3];
    assign dp_linha    = pipe_q[0][2:0];

endmodule

// File: tb/tb_controlador_matriz.sv
// tb/tb_controlador_matriz.sv - self-checking bench for controlador_matriz at DP_LATENCY 1 and 3
module tb_controlador_matriz;
    localparam int MAXW = 20;

    typedef struct {
        logic [199:0] a;
        logic [199:0] b;
        logic [199:0] exp;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset, start, start3;
    logic [199:0] matriz_a, matriz_b, a3, b3;
    logic         busy1, done1, dp_valid1, busy3, done3, dp_valid3;
    logic [2:0]   dp_linha1, dp_linha3;
    logic [199:0] res1, dpa1, dpb1, res3, dpa3, dpb3;
    logic [39:0]  dpr1, dpr3, s1, s2;
    logic [199:0] q1[$];
    logic [199:0] q3[$];
    int           n_cmp = 0, n_err = 0, done_cnt1 = 0, done_cnt3 = 0;

    always #5 clock = ~clock;

    function automatic logic [39:0] row_of(input logic [199:0] a, input logic [199:0] b, input logic [2:0] l);
        logic [39:0]      r;
        logic signed [7:0] ea, eb;
        int               acc, li;
        r  = '0;
        li = int'(l);
        if (li > 4) return r;
        for (int j = 0; j < 5; j++) begin
            acc = 0;
            for (int k = 0; k < 5; k++) begin
                ea  = a[8*(k+5*li) +: 8];
                eb  = b[8*(j+5*k) +: 8];
                acc += int'(ea) * int'(eb);
            end
            r[8*j +: 8] = acc[7:0];
        end
        return r;
    endfunction

    function automatic logic [199:0] matmul(input logic [199:0] a, input logic [199:0] b);
        logic [199:0] m;
        for (int l = 0; l < 5; l++) m[40*l +: 40] = row_of(a, b, 3'(l));
        return m;
    endfunction

    function automatic logic [199:0] rand200();
        logic [199:0] r;
        r = '0;
        for (int i = 0; i < 7; i++) r = (r << 32) | 200'($urandom());
        return r;
    endfunction

    // Datapath models: combinational for latency 1, two register stages for latency 3.
    assign dpr1 = row_of(dpa1, dpb1, dp_linha1);
    always @(posedge clock) begin
        s1 <= row_of(dpa3, dpb3, dp_linha3);
        s2 <= s1;
    end
    assign dpr3 = s2;

    controlador_matriz #(.DP_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .matriz_a(matriz_a), .matriz_b(matriz_b),
        .busy(busy1), .done(done1), .resultado(res1), .dp_matriz_a(dpa1), .dp_matriz_b(dpb1),
        .dp_linha(dp_linha1), .dp_valid(dp_valid1), .dp_linha_resultado(dpr1)
    );

    controlador_matriz #(.DP_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .matriz_a(a3), .matriz_b(b3),
        .busy(busy3), .done(done3), .resultado(res3), .dp_matriz_a(dpa3), .dp_matriz_b(dpb3),
        .dp_linha(dp_linha3), .dp_valid(dp_valid3), .dp_linha_resultado(dpr3)
    );

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) check("unexpected_done1", 1'b1, 1'b0);
            else check("result1", res1, q1.pop_front());
        end
        if (done3) begin
            done_cnt3++;
            if (q3.size() == 0) check("unexpected_done3", 1'b1, 1'b0);
            else check("result3", res3, q3.pop_front());
        end
    end

    // mode 0 plain, 1 operand scramble, 2 start re-pulses, 3 start held high
    task automatic op1(input logic [199:0] a, input logic [199:0] b, input logic [199:0] ex, input int mode);
        int done_at = -1;
        int rows    = 0;
        int dc0     = done_cnt1;
        matriz_a = a;
        matriz_b = b;
        start    = 1'b1;
        q1.push_back(ex);
        if (mode == 3) q1.push_back(ex);
        @(posedge clock); #1;
        if (mode != 3) start = 1'b0;
        check("busy_at_accept", busy1, 1'b1);
        for (int n = 0; n < MAXW; n++) begin
            if (done_at >= 0 && n > done_at + 1) break;
            if (dp_valid1) begin
                check("issue_row", dp_linha1, rows[2:0]);
                check("issue_cycle", n, rows);
                rows++;
            end
            if (done_at >= 0) begin
                check("done_width", done1, 1'b0);
                check("busy_idle", busy1, 1'b0);
            end else if (done1) begin
                done_at = n;
            end
            if (mode == 1 && done_at < 0) begin
                check("hold_a", dpa1, a);
                check("hold_b", dpb1, b);
                matriz_a = rand200();
                matriz_b = rand200();
            end
            if (mode == 2) begin
                start = (n == 1 || n == done_at);
                if (start) matriz_a = ~a;
            end
            @(posedge clock); #1;
        end
        check("done_latency", done_at, 5);
        check("rows_issued", rows, 5);
        if (mode == 3) begin
            check("held_start_reaccept", busy1, 1'b1);
            start   = 1'b0;
            done_at = -1;
            for (int k = 0; k < MAXW && done_at < 0; k++) begin
                if (done1) done_at = k;
                else begin @(posedge clock); #1; end
            end
            check("second_latency", done_at, 5);
            @(posedge clock); #1;
        end else begin
            check("no_reaccept", busy1, 1'b0);
        end
        check("done_count", done_cnt1 - dc0, (mode == 3) ? 2 : 1);
    endtask

    task automatic op3(input logic [199:0] a, input logic [199:0] b, input logic [199:0] ex, input bit prog);
        int           done_at = -1;
        logic [199:0] m;
        a3     = a;
        b3     = b;
        start3 = 1'b1;
        q3.push_back(ex);
        @(posedge clock); #1;
        start3 = 1'b0;
        for (int n = 0; n < MAXW && done_at < 0; n++) begin
            if (prog) begin
                m = '0;
                for (int r = 0; r < 5; r++) if (r + 3 <= n) m[40*r +: 40] = '1;
                check("l3_partial", res3, ex & m);
            end
            if (done3) done_at = n;
            else begin @(posedge clock); #1; end
        end
        check("l3_latency", done_at, 7);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t         vecs[6];
        logic [199:0] ident, bseq, ra, rb;
        int           dc;

        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        matriz_a = '0; matriz_b = '0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_dp_valid", dp_valid1, 1'b0);
        check("rst_dp_linha", dp_linha1, 3'd0);
        check("rst_resultado", res1, '0);
        check("rst_dp_a", dpa1, '0);
        check("rst_dp_b", dpb1, '0);
        reset = 1'b0;

        for (int l = 0; l < 5; l++) begin
            for (int c = 0; c < 5; c++) begin
                ident[8*(c+5*l) +: 8] = (l == c) ? 8'd1 : 8'd0;
                bseq[8*(c+5*l) +: 8]  = 8'(5*l + c);
            end
        end
        vecs[0] = '{a: ident, b: bseq, exp: bseq};
        vecs[1] = '{a: {25{8'h10}}, b: {25{8'h10}}, exp: {25{8'h00}}};
        vecs[2] = '{a: {25{8'h02}}, b: {25{8'h02}}, exp: {25{8'h14}}};
        vecs[3] = '{a: {25{8'hFF}}, b: {25{8'h01}}, exp: {25{8'hFB}}};
        ra = rand200();
        rb = rand200();
        vecs[4] = '{a: ra, b: rb, exp: matmul(ra, rb)};
        ra = rand200();
        vecs[5] = '{a: ra, b: ident, exp: ra};

        for (int i = 0; i < 6; i++) op1(vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        op1(vecs[2].a, vecs[2].b, vecs[2].exp, 2);
        op1(vecs[3].a, vecs[3].b, vecs[3].exp, 3);
        op1(vecs[4].a, vecs[4].b, vecs[4].exp, 1);

        matriz_a = vecs[4].a;
        matriz_b = vecs[4].b;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("third_issue_valid", dp_valid1, 1'b1);
        check("third_issue_row", dp_linha1, 3'd2);
        dc    = done_cnt1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_busy", busy1, 1'b0);
        check("abort_dp_valid", dp_valid1, 1'b0);
        check("abort_resultado", res1, '0);
        check("abort_done", done1, 1'b0);
        check("abort_dp_a", dpa1, '0);
        reset = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt1 - dc, 0);
        op1(vecs[0].a, vecs[0].b, vecs[0].exp, 0);

        op3(vecs[4].a, vecs[4].b, vecs[4].exp, 1'b1);
        op3(vecs[3].a, vecs[3].b, vecs[3].exp, 1'b0);
        op3(vecs[5].a, vecs[5].b, vecs[5].exp, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("q1_drained", q1.size(), 0);
        check("q3_drained", q3.size(), 0);
        check("dut3_done_count", done_cnt3, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
